// File: rtl/core_l1i_resp_pkg.sv
// Shared defaults, FSM encoding and geometry helpers for the L1I responder.
// Imported by the array and the top so both agree on field widths.
package core_l1i_resp_pkg;

  localparam int L1I_INDEX_W    = 6;
  localparam int L1I_LINE_WORDS = 4;
  localparam int L1I_ADDR_W     = 32;

  typedef enum logic [1:0] {
    L1I_IDLE   = 2'd0,
    L1I_REQ    = 2'd1,
    L1I_REFILL = 2'd2,
    L1I_DONE   = 2'd3
  } l1i_state_e;

  // Tag width left over once byte, word-offset and index bits are removed.
  function automatic int l1i_tag_w(input int addr_w, input int index_w, input int line_words);
    return addr_w - index_w - $clog2(line_words) - 2;
  endfunction

endpackage

// File: rtl/core_l1i_array.sv
// Direct-mapped tag/valid/data storage: one combinational read port, one word
// write port, a tag+valid set port and a global valid clear.
module core_l1i_array
  import core_l1i_resp_pkg::*;
#(
  parameter int INDEX_W    = L1I_INDEX_W,
  parameter int LINE_WORDS = L1I_LINE_WORDS,
  parameter int TAG_W      = 22,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int NLINES    = 1 << INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0]   rd_off_i,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic               rd_valid_o,
  output logic [31:0]        rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0]   wr_off_i,
  input  logic [31:0]        wr_data_i,
  input  logic               set_en_i,
  input  logic [INDEX_W-1:0] set_idx_i,
  input  logic [TAG_W-1:0]   set_tag_i,
  input  logic               clr_all_i
);

  logic [NLINES-1:0]                       valid_q;
  logic [NLINES-1:0][TAG_W-1:0]            tag_q;
  logic [NLINES-1:0][LINE_WORDS-1:0][31:0] data_q;

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

  // Only the valid bits need a reset; tag and data are qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_all_i) valid_q <= '0;
      if (set_en_i)  valid_q[set_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en_i) tag_q[set_idx_i] <= set_tag_i;
    if (wr_en_i)  data_q[wr_idx_i][wr_off_i] <= wr_data_i;
  end

endmodule

// File: rtl/core_l1i_resp.sv
// Fetch-side L1I responder: hit path, miss latch, line refill FSM towards the
// memory bus, and the combinational stall used by hazard control.
module core_l1i_resp
  import core_l1i_resp_pkg::*;
#(
  parameter int INDEX_W    = L1I_INDEX_W,
  parameter int LINE_WORDS = L1I_LINE_WORDS,
  parameter int ADDR_W     = L1I_ADDR_W,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int TAG_W     = l1i_tag_w(ADDR_W, INDEX_W, LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] l1i_addr_in,
  input  logic              l1i_val_in,
  input  logic              l1i_flush_in,
  output logic [31:0]       l1i_data_out,
  output logic              l1i_resp_val_out,
  output logic              l1i_stall_out,
  output logic              mem_req_val_out,
  output logic [ADDR_W-1:0] mem_req_addr_out,
  input  logic              mem_req_ack_in,
  input  logic              mem_resp_val_in,
  input  logic [31:0]       mem_resp_data_in
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  l1i_state_e         state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W-1:0]   cnt_q;
  logic               flush_pend_q;
  logic [31:0]        rdata_q;
  logic               resp_val_q;

  logic [OFF_W-1:0]   in_off;
  logic [INDEX_W-1:0] in_idx;
  logic [TAG_W-1:0]   in_tag;
  logic [INDEX_W-1:0] rd_idx;
  logic [OFF_W-1:0]   rd_off;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic [31:0]        rd_data;
  logic               idle, hit, lookup;
  logic               beat, last_beat, set_en;
  logic [1:0]         unused_addr_bits;

  assign in_off = l1i_addr_in[OFF_W+1:2];
  assign in_idx = l1i_addr_in[OFF_W+2 +: INDEX_W];
  assign in_tag = l1i_addr_in[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = l1i_addr_in[1:0];

  // Outside IDLE the read port follows the latched miss so DONE returns its word.
  assign idle   = (state_q == L1I_IDLE);
  assign rd_idx = idle ? in_idx : idx_q;
  assign rd_off = idle ? in_off : off_q;
  assign hit    = rd_valid && (rd_tag == in_tag);
  assign lookup = idle && l1i_val_in;

  assign beat      = (state_q == L1I_REFILL) && mem_resp_val_in;
  assign last_beat = beat && (cnt_q == LAST_BEAT);
  // A flush seen anywhere during the refill keeps the new line invalid.
  assign set_en    = last_beat && !flush_pend_q && !l1i_flush_in;

  assign l1i_stall_out    = (lookup && !hit) || (state_q == L1I_REQ) || (state_q == L1I_REFILL);
  assign l1i_data_out     = rdata_q;
  assign l1i_resp_val_out = resp_val_q;
  assign mem_req_val_out  = (state_q == L1I_REQ);
  assign mem_req_addr_out = {tag_q, idx_q, {(OFF_W+2){1'b0}}};

  core_l1i_array #(
    .INDEX_W    (INDEX_W),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (rd_idx),
    .rd_off_i   (rd_off),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_en_i    (beat),
    .wr_idx_i   (idx_q),
    .wr_off_i   (cnt_q),
    .wr_data_i  (mem_resp_data_in),
    .set_en_i   (set_en),
    .set_idx_i  (idx_q),
    .set_tag_i  (tag_q),
    .clr_all_i  (l1i_flush_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= L1I_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      rdata_q      <= '0;
      resp_val_q   <= 1'b0;
    end else begin
      resp_val_q <= 1'b0;
      case (state_q)
        L1I_IDLE: begin
          if (lookup) begin
            if (hit) begin
              resp_val_q <= 1'b1;
              rdata_q    <= rd_data;
            end else begin
              tag_q   <= in_tag;
              idx_q   <= in_idx;
              off_q   <= in_off;
              state_q <= L1I_REQ;
            end
          end
        end
        L1I_REQ: begin
          if (l1i_flush_in) flush_pend_q <= 1'b1;
          if (mem_req_ack_in) begin
            cnt_q   <= '0;
            state_q <= L1I_REFILL;
          end
        end
        L1I_REFILL: begin
          if (l1i_flush_in) flush_pend_q <= 1'b1;
          if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) state_q <= L1I_DONE;
          end
        end
        L1I_DONE: begin
          resp_val_q   <= 1'b1;
          rdata_q      <= rd_data;
          flush_pend_q <= 1'b0;
          state_q      <= L1I_IDLE;
        end
        default: state_q <= L1I_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_l1i_resp.sv
// Scoreboard bench for core_l1i_resp: the bench plays fetch stage and memory,
// queues expected words at issue and checks data and latency on each response.
module tb_core_l1i_resp;
  localparam int AW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] l1i_addr_in;
  logic          l1i_val_in, l1i_flush_in;
  logic [31:0]   l1i_data_out;
  logic          l1i_resp_val_out, l1i_stall_out;
  logic          mem_req_val_out;
  logic [AW-1:0] mem_req_addr_out;
  logic          mem_req_ack_in, mem_resp_val_in;
  logic [31:0]   mem_resp_data_in;

  core_l1i_resp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .l1i_addr_in      (l1i_addr_in),
    .l1i_val_in       (l1i_val_in),
    .l1i_flush_in     (l1i_flush_in),
    .l1i_data_out     (l1i_data_out),
    .l1i_resp_val_out (l1i_resp_val_out),
    .l1i_stall_out    (l1i_stall_out),
    .mem_req_val_out  (mem_req_val_out),
    .mem_req_addr_out (mem_req_addr_out),
    .mem_req_ack_in   (mem_req_ack_in),
    .mem_resp_val_in  (mem_resp_val_in),
    .mem_resp_data_in (mem_resp_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  // Backing memory: the 0x200 line holds 0x11..0x44, everything else is address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h20) begin
      w = {30'd0, a[3:2]} + 32'd1;
      return 32'h11 * w;
    end
    return {a[31:2], 2'b00} ^ 32'hCAFE_0000;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && l1i_resp_val_out) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL resp_unexpected got data=%h, none expected", l1i_data_out);
      end else begin
        e = exp_q.pop_front();
        if (l1i_data_out !== e.data || (cyc - e.issue) != e.lat)
          $display("FAIL resp got data=%h lat=%0d, need data=%h lat=%0d",
                   l1i_data_out, cyc - e.issue, e.data, e.lat);
        else passed++;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int lat);
    exp_t e;
    l1i_addr_in = a;
    l1i_val_in  = 1'b1;
    #1;
    total++;
    if (l1i_stall_out !== (exp_hit ? 1'b0 : 1'b1))
      $display("FAIL fetch_stall addr=%h got %b need %b", a, l1i_stall_out, !exp_hit);
    else passed++;
    e.data = mem_word(a); e.issue = cyc; e.lat = lat;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic serve_miss(input logic [31:0] a, input int ack_dly, input int gap,
                            input int flush_beat, input int abort_after);
    logic [31:0] base;
    int n;
    l1i_val_in = 1'b0;
    base = {a[31:4], 4'h0};
    n = 0;
    while (!mem_req_val_out && n < 20) begin @(negedge clk); n++; end
    total++;
    if (mem_req_val_out !== 1'b1 || mem_req_addr_out !== base)
      $display("FAIL req_addr got val=%b addr=%h need 1 %h", mem_req_val_out, mem_req_addr_out, base);
    else passed++;
    for (int i = 0; i < ack_dly; i++) begin
      mem_req_ack_in = 1'b0;
      @(negedge clk);
      total++;
      if (mem_req_val_out !== 1'b1 || mem_req_addr_out !== base || l1i_stall_out !== 1'b1)
        $display("FAIL req_hold got val=%b addr=%h stall=%b need 1 %h 1",
                 mem_req_val_out, mem_req_addr_out, l1i_stall_out, base);
      else passed++;
    end
    mem_req_ack_in = 1'b1;
    @(negedge clk);
    mem_req_ack_in = 1'b0;
    for (int w = 0; w < LW; w++) begin
      if (w > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          total++;
          if (l1i_stall_out !== 1'b1) $display("FAIL gap_stall got %b need 1", l1i_stall_out);
          else passed++;
        end
      end
      mem_resp_val_in  = 1'b1;
      mem_resp_data_in = mem_word(base + 32'(4 * w));
      l1i_flush_in     = (w == flush_beat);
      @(negedge clk);
      l1i_flush_in    = 1'b0;
      mem_resp_val_in = 1'b0;
      if (abort_after == w + 1) return;
    end
    total++;
    if (l1i_stall_out !== 1'b0 || mem_req_val_out !== 1'b0)
      $display("FAIL done_stall got stall=%b req=%b need 0 0", l1i_stall_out, mem_req_val_out);
    else passed++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin @(negedge clk); n++; end
    total++;
    if (exp_q.size() != 0) $display("FAIL drain got %0d pending need 0", exp_q.size());
    else passed++;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (l1i_resp_val_out !== 1'b0 || l1i_data_out !== 32'd0 || mem_req_val_out !== 1'b0 ||
        mem_req_addr_out !== 32'd0 || l1i_stall_out !== 1'b0)
      $display("FAIL %s got rv=%b d=%h rq=%b ra=%h st=%b need all zero", tag,
               l1i_resp_val_out, l1i_data_out, mem_req_val_out, mem_req_addr_out, l1i_stall_out);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l1i_addr_in = '0; l1i_val_in = 1'b0; l1i_flush_in = 1'b0;
    mem_req_ack_in = 1'b0; mem_resp_val_in = 1'b0; mem_resp_data_in = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    fetch(32'h200, 1'b0, 7);
    serve_miss(32'h200, 0, 0, -1, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < LW; i++) begin
      fetch(32'h200 + 32'(4 * i), 1'b1, 1);
      total++;
      if (mem_req_val_out !== 1'b0) $display("FAIL hit_noreq got %b need 0", mem_req_val_out);
      else passed++;
    end
    l1i_val_in = 1'b0;
    drain();
  endtask

  task automatic test_conflict();
    fetch(32'h600, 1'b0, 7);
    serve_miss(32'h600, 0, 0, -1, 0);
    drain();
    fetch(32'h200, 1'b0, 7);
    serve_miss(32'h200, 0, 0, -1, 0);
    drain();
  endtask

  task automatic test_handshake();
    fetch(32'h1008, 1'b0, 7 + 3 + (LW - 1));
    serve_miss(32'h1008, 3, 1, -1, 0);
    drain();
  endtask

  task automatic test_flush_idle();
    l1i_flush_in = 1'b1;
    fetch(32'h204, 1'b1, 1);
    l1i_flush_in = 1'b0;
    l1i_val_in   = 1'b0;
    drain();
    fetch(32'h204, 1'b0, 7);
    serve_miss(32'h204, 0, 0, -1, 0);
    drain();
  endtask

  task automatic test_flush_refill();
    fetch(32'h1004, 1'b0, 7);
    serve_miss(32'h1004, 0, 0, 1, 0);
    drain();
    fetch(32'h1004, 1'b0, 7);
    serve_miss(32'h1004, 0, 0, -1, 0);
    drain();
    fetch(32'h100C, 1'b1, 1);
    l1i_val_in = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_refill();
    fetch(32'h600, 1'b0, 7);
    serve_miss(32'h600, 0, 0, -1, 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 2; i < LW; i++) begin
      mem_resp_val_in  = 1'b1;
      mem_resp_data_in = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
      total++;
      if (mem_req_val_out !== 1'b0 || l1i_resp_val_out !== 1'b0 || l1i_stall_out !== 1'b0)
        $display("FAIL stray_beat got rq=%b rv=%b st=%b need 0 0 0",
                 mem_req_val_out, l1i_resp_val_out, l1i_stall_out);
      else passed++;
    end
    mem_resp_val_in = 1'b0;
    fetch(32'h200, 1'b0, 7);
    serve_miss(32'h200, 0, 0, -1, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_handshake();
    test_flush_idle();
    test_flush_refill();
    test_reset_mid_refill();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish within bound");
    $fatal(1);
  end

endmodule
